// File: rtl/polymult_tile_feeder.sv
// polymult_tile_feeder
//   Holds two coefficient polynomials A and B and, on start, sweeps every
//   (A tile, B tile) pair out to a tile multiplier: B is the inner loop and
//   A the outer loop, giving NT*NT transfers per sweep.
//
// Ports
//   clk                   : single clock, rising edge
//   rst                   : asynchronous, active-low reset
//   load_valid/load_sel   : coefficient write strobe; sel 0 = A, 1 = B
//   load_addr/load_data   : coefficient index and value
//   start                 : request a full sweep (honoured only in IDLE)
//   ready_for_tile        : multiplier accepts the presented tile pair
//   tile_a/tile_b         : presented tiles, element 0 in the LSBs
//   inputs_ready_signal   : tile_a/tile_b valid
//   tile_idx_a/tile_idx_b : indices of the presented tiles
//   busy                  : high whenever the FSM is not in IDLE
//   done                  : one-cycle pulse when the sweep completes
// All outputs are registered. Coefficient storage is not reset.
module polymult_tile_feeder #(
  parameter int DATA_WIDTH = 64,
  parameter int TILE_WIDTH = 8,
  parameter int POLY_WIDTH = 64,
  localparam int NT = POLY_WIDTH / TILE_WIDTH,
  localparam int AW = (POLY_WIDTH > 1) ? $clog2(POLY_WIDTH) : 1,
  localparam int IW = (NT > 1) ? $clog2(NT) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             load_valid,
  input  logic                             load_sel,
  input  logic [AW-1:0]                    load_addr,
  input  logic [DATA_WIDTH-1:0]            load_data,
  input  logic                             start,
  input  logic                             ready_for_tile,
  output logic [TILE_WIDTH*DATA_WIDTH-1:0] tile_a,
  output logic [TILE_WIDTH*DATA_WIDTH-1:0] tile_b,
  output logic                             inputs_ready_signal,
  output logic [IW-1:0]                    tile_idx_a,
  output logic [IW-1:0]                    tile_idx_b,
  output logic                             busy,
  output logic                             done
);

  typedef enum logic [1:0] {IDLE, ISSUE, FINISH} state_t;

  state_t state;

  logic [DATA_WIDTH-1:0] mem_a [POLY_WIDTH];
  logic [DATA_WIDTH-1:0] mem_b [POLY_WIDTH];

  logic                             wr_en;
  logic                             xfer;
  logic                             last_a;
  logic                             last_b;
  logic [IW-1:0]                    fetch_a;
  logic [IW-1:0]                    fetch_b;
  logic [TILE_WIDTH*DATA_WIDTH-1:0] fetch_tile_a;
  logic [TILE_WIDTH*DATA_WIDTH-1:0] fetch_tile_b;

  function automatic logic [AW-1:0] coef_addr(input logic [IW-1:0] idx,
                                              input int unsigned k);
    return AW'(32'(idx) * 32'(TILE_WIDTH) + k);
  endfunction

  assign wr_en  = (state == IDLE) && load_valid;
  assign xfer   = (state == ISSUE) && ready_for_tile;
  assign last_a = (tile_idx_a == IW'(NT - 1));
  assign last_b = (tile_idx_b == IW'(NT - 1));

  // Pair to present after the next edge: (0,0) when leaving IDLE,
  // otherwise the successor of the current pair.
  always_comb begin
    fetch_a = tile_idx_a;
    fetch_b = tile_idx_b;
    if (state == IDLE) begin
      fetch_a = '0;
      fetch_b = '0;
    end else if (last_b) begin
      fetch_a = tile_idx_a + 1'b1;
      fetch_b = '0;
    end else begin
      fetch_b = tile_idx_b + 1'b1;
    end
  end

  // A write landing on the same edge as start must already be visible in
  // the first tile pair, so the write data is forwarded past the array.
  always_comb begin
    fetch_tile_a = '0;
    fetch_tile_b = '0;
    for (int unsigned k = 0; k < TILE_WIDTH; k++) begin
      fetch_tile_a[k*DATA_WIDTH +: DATA_WIDTH] =
        (wr_en && !load_sel && (load_addr == coef_addr(fetch_a, k)))
          ? load_data : mem_a[coef_addr(fetch_a, k)];
      fetch_tile_b[k*DATA_WIDTH +: DATA_WIDTH] =
        (wr_en && load_sel && (load_addr == coef_addr(fetch_b, k)))
          ? load_data : mem_b[coef_addr(fetch_b, k)];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (load_sel) begin
        mem_b[load_addr] <= load_data;
      end else begin
        mem_a[load_addr] <= load_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state               <= IDLE;
      inputs_ready_signal <= 1'b0;
      busy                <= 1'b0;
      done                <= 1'b0;
      tile_idx_a          <= '0;
      tile_idx_b          <= '0;
      tile_a              <= '0;
      tile_b              <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state               <= ISSUE;
            inputs_ready_signal <= 1'b1;
            busy                <= 1'b1;
            tile_idx_a          <= fetch_a;
            tile_idx_b          <= fetch_b;
            tile_a              <= fetch_tile_a;
            tile_b              <= fetch_tile_b;
          end
        end
        ISSUE: begin
          if (xfer) begin
            if (last_a && last_b) begin
              state               <= FINISH;
              inputs_ready_signal <= 1'b0;
              done                <= 1'b1;
            end else begin
              tile_idx_a <= fetch_a;
              tile_idx_b <= fetch_b;
              tile_a     <= fetch_tile_a;
              tile_b     <= fetch_tile_b;
            end
          end
        end
        FINISH: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state               <= IDLE;
          inputs_ready_signal <= 1'b0;
          busy                <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_polymult_tile_feeder.sv
// Testbench for polymult_tile_feeder: scoreboard of expected tile pairs
// pushed when a sweep is started and popped on every observed transfer.
module tb_polymult_tile_feeder;

  localparam int DW = 64;
  localparam int TW = 8;
  localparam int PW = 64;
  localparam int NT = PW / TW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load_valid = 1'b0;
  logic          load_sel = 1'b0;
  logic [5:0]    load_addr = '0;
  logic [DW-1:0] load_data = '0;
  logic          start = 1'b0;
  logic          ready_for_tile = 1'b0;
  logic [TW*DW-1:0] tile_a, tile_b;
  logic          inputs_ready_signal, busy, done;
  logic [2:0]    tile_idx_a, tile_idx_b;

  always #5 clk = ~clk;

  polymult_tile_feeder #(
    .DATA_WIDTH(DW),
    .TILE_WIDTH(TW),
    .POLY_WIDTH(PW)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .load_valid         (load_valid),
    .load_sel           (load_sel),
    .load_addr          (load_addr),
    .load_data          (load_data),
    .start              (start),
    .ready_for_tile     (ready_for_tile),
    .tile_a             (tile_a),
    .tile_b             (tile_b),
    .inputs_ready_signal(inputs_ready_signal),
    .tile_idx_a         (tile_idx_a),
    .tile_idx_b         (tile_idx_b),
    .busy               (busy),
    .done               (done)
  );

  typedef struct {
    logic [2:0]     ia;
    logic [2:0]     ib;
    logic [TW*DW-1:0] ta;
    logic [TW*DW-1:0] tb;
  } exp_t;

  exp_t          sbq[$];
  exp_t          e;
  logic [DW-1:0] ma [PW];
  logic [DW-1:0] mb [PW];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int xfer_cnt = 0;
  int done_cnt = 0;
  int first_xfer_cyc = 0;
  int last_xfer_cyc = 0;
  int done_cyc = 0;

  bit               hold_pend = 1'b0;
  logic [2:0]       h_ia, h_ib;
  logic [TW*DW-1:0] h_ta, h_tb;

  always @(posedge clk) cyc++;

  // Transfer monitor / scoreboard and stall-stability check.
  always @(negedge clk) begin
    if (hold_pend && inputs_ready_signal === 1'b1) begin
      total++;
      if ({tile_idx_a, tile_idx_b, tile_a, tile_b} !== {h_ia, h_ib, h_ta, h_tb}) begin
        bad++;
        $display("FAIL stall_hold: got idx=(%0d,%0d) a0=%h b0=%h, held idx=(%0d,%0d) a0=%h b0=%h",
                 tile_idx_a, tile_idx_b, tile_a[DW-1:0], tile_b[DW-1:0],
                 h_ia, h_ib, h_ta[DW-1:0], h_tb[DW-1:0]);
      end
    end
    hold_pend = (inputs_ready_signal === 1'b1) && (ready_for_tile === 1'b0);
    h_ia = tile_idx_a; h_ib = tile_idx_b; h_ta = tile_a; h_tb = tile_b;

    if (inputs_ready_signal === 1'b1 && ready_for_tile === 1'b1) begin
      if (xfer_cnt == 0) first_xfer_cyc = cyc;
      last_xfer_cyc = cyc;
      xfer_cnt++;
      total++;
      if (sbq.size() == 0) begin
        bad++;
        $display("FAIL xfer_unexpected: got idx=(%0d,%0d), required no transfer",
                 tile_idx_a, tile_idx_b);
      end else begin
        e = sbq.pop_front();
        if ({tile_idx_a, tile_idx_b, tile_a, tile_b} !== {e.ia, e.ib, e.ta, e.tb}) begin
          bad++;
          $display("FAIL xfer_data: got idx=(%0d,%0d) a0=%h a7=%h b0=%h b7=%h, required idx=(%0d,%0d) a0=%h a7=%h b0=%h b7=%h",
                   tile_idx_a, tile_idx_b, tile_a[DW-1:0], tile_a[TW*DW-1 -: DW],
                   tile_b[DW-1:0], tile_b[TW*DW-1 -: DW],
                   e.ia, e.ib, e.ta[DW-1:0], e.ta[TW*DW-1 -: DW],
                   e.tb[DW-1:0], e.tb[TW*DW-1 -: DW]);
        end
      end
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  function automatic void push_sweep();
    exp_t x;
    for (int a = 0; a < NT; a++) begin
      for (int b = 0; b < NT; b++) begin
        x.ia = 3'(a);
        x.ib = 3'(b);
        for (int k = 0; k < TW; k++) begin
          x.ta[k*DW +: DW] = ma[a*TW + k];
          x.tb[k*DW +: DW] = mb[b*TW + k];
        end
        sbq.push_back(x);
      end
    end
  endfunction

  task automatic clear_counts();
    xfer_cnt = 0;
    done_cnt = 0;
  endtask

  task automatic kick();
    @(posedge clk); #1;
    start = 1'b1;
    push_sweep();
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    #1;
    total++;
    if ({inputs_ready_signal, busy, done, tile_idx_a, tile_idx_b} !== '0 ||
        tile_a !== '0 || tile_b !== '0) begin
      bad++;
      $display("FAIL reset_state: got irs=%b busy=%b done=%b idx=(%0d,%0d) a0=%h b0=%h, required all zero",
               inputs_ready_signal, busy, done, tile_idx_a, tile_idx_b,
               tile_a[DW-1:0], tile_b[DW-1:0]);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_load();
    for (int n = 0; n < PW; n++) begin
      ma[n] = DW'(n);
      mb[n] = DW'(32'h100 + n);
    end
    ready_for_tile = 1'b1;  // no effect while nothing is presented
    for (int n = 0; n < 2*PW; n++) begin
      @(posedge clk); #1;
      load_valid = 1'b1;
      load_sel   = (n >= PW);
      load_addr  = 6'(n % PW);
      load_data  = (n >= PW) ? mb[n % PW] : ma[n % PW];
    end
    @(posedge clk); #1;
    load_valid = 1'b0;
    total++;
    if ({busy, inputs_ready_signal, done, tile_idx_a, tile_idx_b} !== '0) begin
      bad++;
      $display("FAIL idle_after_load: got busy=%b irs=%b done=%b idx=(%0d,%0d), required all zero",
               busy, inputs_ready_signal, done, tile_idx_a, tile_idx_b);
    end
  endtask

  task automatic test_full_sweep();
    bit to;
    clear_counts();
    ready_for_tile = 1'b1;
    kick();
    total++;
    if ({inputs_ready_signal, busy, tile_idx_a, tile_idx_b} !== {1'b1, 1'b1, 3'd0, 3'd0} ||
        tile_a[DW-1:0] !== 64'h0 || tile_b[DW-1:0] !== 64'h100) begin
      bad++;
      $display("FAIL first_pair: got irs=%b busy=%b idx=(%0d,%0d) a0=%h b0=%h, required 1 1 (0,0) 0 100",
               inputs_ready_signal, busy, tile_idx_a, tile_idx_b, tile_a[DW-1:0], tile_b[DW-1:0]);
    end
    wait_done(200, to);
    total++;
    if (to) begin
      bad++;
      $display("FAIL full_timeout: got no done, required done within 200 cycles");
    end
    @(posedge clk); #1;
    total++;
    if (xfer_cnt != 64 || done_cnt != 1 || sbq.size() != 0) begin
      bad++;
      $display("FAIL full_counts: got xfers=%0d dones=%0d left=%0d, required 64 1 0",
               xfer_cnt, done_cnt, sbq.size());
    end
    total++;
    if (done_cyc != last_xfer_cyc + 1 || done_cyc - first_xfer_cyc != 64) begin
      bad++;
      $display("FAIL full_timing: got done-last=%0d done-first=%0d, required 1 64",
               done_cyc - last_xfer_cyc, done_cyc - first_xfer_cyc);
    end
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL full_return_idle: got done=%b busy=%b, required 0 0", done, busy);
    end
  endtask

  task automatic test_stall();
    bit seen;
    seen = 1'b0;
    clear_counts();
    ready_for_tile = 1'b1;
    kick();
    for (int i = 1; i < 400 && !seen; i++) begin
      @(posedge clk); #1;
      ready_for_tile = (i % 3 == 0);
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    ready_for_tile = 1'b1;
    @(posedge clk); #1;
    total++;
    if (!seen || xfer_cnt != 64 || done_cnt != 1 || sbq.size() != 0) begin
      bad++;
      $display("FAIL stall_counts: got done_seen=%0d xfers=%0d dones=%0d left=%0d, required 1 64 1 0",
               seen, xfer_cnt, done_cnt, sbq.size());
    end
  endtask

  task automatic test_busy_write();
    bit to;
    clear_counts();
    ready_for_tile = 1'b1;
    kick();
    repeat (5) @(posedge clk);
    #1;
    load_valid = 1'b1;
    load_sel   = 1'b0;
    load_addr  = 6'd5;
    load_data  = 64'hDEAD;
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL busy_during_write: got busy=%b, required 1", busy);
    end
    @(posedge clk); #1;
    load_valid = 1'b0;
    wait_done(200, to);
    @(posedge clk); #1;
    clear_counts();
    kick();
    wait_done(200, to);
    @(posedge clk); #1;
    total++;
    if (to || xfer_cnt != 64 || done_cnt != 1 || sbq.size() != 0) begin
      bad++;
      $display("FAIL busy_write_resweep: got timeout=%0d xfers=%0d dones=%0d left=%0d, required 0 64 1 0",
               to, xfer_cnt, done_cnt, sbq.size());
    end
  endtask

  task automatic test_start_while_busy();
    bit to;
    clear_counts();
    ready_for_tile = 1'b1;
    kick();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (xfer_cnt >= 20) break;
    end
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    wait_done(200, to);
    @(posedge clk); #1;
    total++;
    if (to || xfer_cnt != 64 || done_cnt != 1 || sbq.size() != 0) begin
      bad++;
      $display("FAIL restart_ignored: got timeout=%0d xfers=%0d dones=%0d left=%0d, required 0 64 1 0",
               to, xfer_cnt, done_cnt, sbq.size());
    end
    repeat (10) @(posedge clk);
    #1;
    total++;
    if (done_cnt != 1 || busy !== 1'b0 || inputs_ready_signal !== 1'b0) begin
      bad++;
      $display("FAIL restart_quiet: got dones=%0d busy=%b irs=%b, required 1 0 0",
               done_cnt, busy, inputs_ready_signal);
    end
  endtask

  task automatic test_back_to_back();
    bit to;
    clear_counts();
    ready_for_tile = 1'b1;
    kick();
    wait_done(200, to);
    @(posedge clk); #1;
    start = 1'b1;
    push_sweep();
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL b2b_idle_gap: got busy=%b, required 0", busy);
    end
    @(posedge clk); #1;
    start = 1'b0;
    total++;
    if ({inputs_ready_signal, tile_idx_a, tile_idx_b} !== {1'b1, 3'd0, 3'd0}) begin
      bad++;
      $display("FAIL b2b_first_pair: got irs=%b idx=(%0d,%0d), required 1 (0,0)",
               inputs_ready_signal, tile_idx_a, tile_idx_b);
    end
    wait_done(200, to);
    @(posedge clk); #1;
    total++;
    if (to || xfer_cnt != 128 || done_cnt != 2 || sbq.size() != 0) begin
      bad++;
      $display("FAIL b2b_counts: got timeout=%0d xfers=%0d dones=%0d left=%0d, required 0 128 2 0",
               to, xfer_cnt, done_cnt, sbq.size());
    end
  endtask

  task automatic test_reset_mid();
    bit to;
    bit reached;
    reached = 1'b0;
    clear_counts();
    ready_for_tile = 1'b1;
    kick();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (xfer_cnt >= 30) begin
        reached = 1'b1;
        break;
      end
    end
    total++;
    if (!reached) begin
      bad++;
      $display("FAIL rst_mid_reach: got xfers=%0d, required 30", xfer_cnt);
    end
    #1 rst = 1'b0;
    sbq.delete();
    #1;
    total++;
    if ({inputs_ready_signal, busy, done, tile_idx_a, tile_idx_b} !== '0 ||
        tile_a !== '0 || tile_b !== '0) begin
      bad++;
      $display("FAIL rst_mid_async: got irs=%b busy=%b done=%b idx=(%0d,%0d) a0=%h b0=%h, required all zero",
               inputs_ready_signal, busy, done, tile_idx_a, tile_idx_b,
               tile_a[DW-1:0], tile_b[DW-1:0]);
    end
    @(negedge clk); #2;
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    total++;
    if (done_cnt != 0 || busy !== 1'b0 || inputs_ready_signal !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_no_done: got dones=%0d busy=%b irs=%b, required 0 0 0",
               done_cnt, busy, inputs_ready_signal);
    end
    clear_counts();
    kick();
    total++;
    if ({inputs_ready_signal, tile_idx_a, tile_idx_b} !== {1'b1, 3'd0, 3'd0} ||
        tile_a[DW-1:0] !== ma[0] || tile_b[DW-1:0] !== mb[0]) begin
      bad++;
      $display("FAIL rst_restart_pair: got irs=%b idx=(%0d,%0d) a0=%h b0=%h, required 1 (0,0) %h %h",
               inputs_ready_signal, tile_idx_a, tile_idx_b, tile_a[DW-1:0], tile_b[DW-1:0],
               ma[0], mb[0]);
    end
    wait_done(200, to);
    @(posedge clk); #1;
    total++;
    if (to || xfer_cnt != 64 || done_cnt != 1 || sbq.size() != 0) begin
      bad++;
      $display("FAIL rst_restart_counts: got timeout=%0d xfers=%0d dones=%0d left=%0d, required 0 64 1 0",
               to, xfer_cnt, done_cnt, sbq.size());
    end
  endtask

  task automatic test_start_with_load();
    bit to;
    clear_counts();
    ready_for_tile = 1'b1;
    @(posedge clk); #1;
    start      = 1'b1;
    load_valid = 1'b1;
    load_sel   = 1'b1;
    load_addr  = 6'd2;
    load_data  = 64'hBEEF;
    mb[2]      = 64'hBEEF;
    push_sweep();
    @(posedge clk); #1;
    start      = 1'b0;
    load_valid = 1'b0;
    wait_done(200, to);
    @(posedge clk); #1;
    total++;
    if (to || xfer_cnt != 64 || done_cnt != 1 || sbq.size() != 0) begin
      bad++;
      $display("FAIL start_load_counts: got timeout=%0d xfers=%0d dones=%0d left=%0d, required 0 64 1 0",
               to, xfer_cnt, done_cnt, sbq.size());
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load();
    test_full_sweep();
    test_stall();
    test_busy_write();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid();
    test_start_with_load();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/polymult_tile_feeder.md
POLYMULT_TILE_FEEDER -- requirements
Module: polymult_tile_feeder

Interface
REQ-001: Parameter DATA_WIDTH, default 64, SHALL set the coefficient width in bits.
REQ-002: Parameter TILE_WIDTH, default 8, SHALL set the coefficients per tile.
REQ-003: Parameter POLY_WIDTH, default 64, SHALL set the coefficients per polynomial; it SHALL be a multiple of TILE_WIDTH, with NT = POLY_WIDTH/TILE_WIDTH.
REQ-004: clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-005: rst  input  1  SHALL be the reset: asynchronous, active-low.
REQ-006: load_valid  input  1  SHALL qualify a coefficient write.
REQ-007: load_sel  input  1  SHALL select the target polynomial (0 = A, 1 = B).
REQ-008: load_addr  input  clog2(POLY_WIDTH)  SHALL give the coefficient index.
REQ-009: load_data  input  DATA_WIDTH  SHALL give the coefficient value.
REQ-010: start  input  1  SHALL request a full tile sweep.
REQ-011: ready_for_tile  input  1  SHALL indicate that the multiplier accepts a tile pair.
REQ-012: tile_a, tile_b  output  TILE_WIDTH x DATA_WIDTH (packed, element 0 in the LSBs)  SHALL carry the current tile pair.
REQ-013: inputs_ready_signal  output  1  SHALL indicate that tile_a/tile_b are valid.
REQ-014: tile_idx_a, tile_idx_b  output  clog2(NT)  SHALL give the indices of the tiles currently presented.
REQ-015: busy  output  1  SHALL be high while the block is not in IDLE.
REQ-016: done  output  1  SHALL be a one-cycle sweep-complete pulse.

Function
REQ-017: FSM states SHALL be IDLE, ISSUE and FINISH.
REQ-018: In IDLE, load_valid=1 SHALL write load_data to A[load_addr] or B[load_addr] at the next edge.
REQ-019: Writes while busy=1 SHALL be ignored; stored coefficients SHALL be unchanged.
REQ-020: Transition IDLE->ISSUE SHALL occur on start=1 in IDLE; if start and load_valid are both high, the write SHALL also complete.
REQ-021: In ISSUE, inputs_ready_signal SHALL be 1, with tile_a[k]=A[tile_idx_a*TILE_WIDTH+k] and tile_b[k]=B[tile_idx_b*TILE_WIDTH+k].
REQ-022: The first pair (0,0) SHALL be presented in the cycle after start is sampled.
REQ-023: A transfer SHALL occur on an edge where inputs_ready_signal=1 and ready_for_tile=1.
REQ-024: Without a transfer, tile_a, tile_b and both indices SHALL hold stable.
REQ-025: After each transfer, tile_idx_b SHALL increment.
REQ-026: On tile_idx_b wrap from NT-1 to 0, tile_idx_a SHALL increment (B inner loop, A outer loop).
REQ-027: With ready_for_tile held high, transfers SHALL occur every cycle with no bubbles.
REQ-028: Exactly NT*NT transfers SHALL occur per sweep.
REQ-029: The transfer of pair (NT-1,NT-1) SHALL move the FSM to FINISH.
REQ-030: In FINISH, inputs_ready_signal SHALL be 0 and done SHALL be 1 for exactly one cycle; the FSM SHALL then return to IDLE.
REQ-031: start asserted while busy=1 SHALL be ignored.
REQ-032: A start in the cycle immediately after FINISH SHALL begin a new sweep normally.
REQ-033: ready_for_tile asserted while inputs_ready_signal=0 SHALL have no effect.
REQ-034: All outputs SHALL be registered; no combinational path SHALL run from any input to any output.

Reset
REQ-035: rst=0 SHALL immediately force state=IDLE and set inputs_ready_signal, busy, done, tile_idx_a and tile_idx_b to 0, and tile_a and tile_b to all-zero, regardless of clk.
REQ-036: Reset asserted mid-sweep SHALL abort the sweep with no done pulse.
REQ-037: Coefficient storage SHALL NOT be reset and SHALL retain its contents across reset.
REQ-038: The first start after reset release SHALL restart at pair (0,0).

Verification
REQ-039: Load A[n]=n and B[n]=0x100+n, start, ready_for_tile=1 constant -> 64 consecutive transfers; pair 0 has tile_a[0]=0 and tile_b[0]=0x100; pair 9 has indices (1,1), tile_a[0]=8 and tile_b[0]=0x108; done=1 exactly 1 cycle after the 64th transfer.
REQ-040: Same load, ready_for_tile toggling 1,0,0,1,... -> tiles and indices stay stable during 0 cycles; still exactly 64 transfers in (a,b) order.
REQ-041: A write to A[5]=0xDEAD issued while busy -> after done, a second sweep shows A[5] unchanged.
REQ-042: start pulsed again at transfer 20 -> ignored; total transfers = 64; one done pulse.
REQ-043: rst=0 for 1 cycle at transfer 30 -> outputs zero asynchronously, no done; next start restarts at (0,0) with the original data intact.
